subinst_rr_arbiter: RTL and testbench
=====================================

# subinst_rr_arbiter

Round-robin arbiter that shares one common resource among the five child instances of a root module (`inst_0`..`inst_4`). Each child raises a request. The arbiter grants exactly one owner at a time and holds the grant until the owner signals done, drops its request, or exceeds a hold timeout. Grant ownership then rotates fairly. It sits in the root module beside the child instances, and its grant vector drives the shared-resource mux select.

## Interface
- `NUM_REQ`, default 5: number of requesters, legal range 2..16.
- `TIMEOUT`, default 16: maximum grant length in cycles, legal range 2..65535.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  NUM_REQ: per-child request, level-sensitive.
- `done`  in  NUM_REQ: per-child release strobe; sampled only for the current owner.
- `gnt`  out  NUM_REQ: one-hot grant, or all-zero when idle.
- `gnt_valid`  out  1: high while any grant is active; equals `|gnt`.
- `gnt_id`  out  $clog2(NUM_REQ): index of the current owner; holds its last value when idle.
- `timeout_pulse`  out  1: one-cycle strobe when a grant is force-released by timeout.

## Operation
- State machine: IDLE, GRANT, RELEASE.
- IDLE:
  - If `req` is non-zero, select the first requester at or after `ptr`, searching upward with wrap from NUM_REQ-1 to 0.
  - Register that requester into `gnt` and `gnt_id`, clear `hold_cnt`, then go to GRANT.
- GRANT: `hold_cnt` increments each cycle. Release conditions are evaluated in priority order:
  - `done[gnt_id]`=1: normal release.
  - `req[gnt_id]`=0: abandon release.
  - `hold_cnt`==TIMEOUT-1: forced release; assert `timeout_pulse` for one cycle.
- On any release:
  - `gnt` clears at the next edge.
  - `ptr` is set to `gnt_id`+1, wrapping from NUM_REQ-1 to 0.
  - State goes to RELEASE.
- RELEASE: one mandatory bubble cycle with `gnt`=0, then IDLE. This guarantees at least one idle cycle between grants, so the mux select never switches owner back to back.
- `done` bits from non-owners are ignored in every state. `done` in IDLE is ignored.
- If `done` and timeout coincide, the release is treated as normal: no `timeout_pulse`.
- A requester that re-asserts `req` immediately after its own release is served again only after every other pending requester has been served once.
- Arithmetic:
  - `hold_cnt` is $clog2(TIMEOUT) bits, unsigned, and never wraps; it saturates at the release point.
  - `ptr` and `gnt_id` are $clog2(NUM_REQ) bits and wrap modulo NUM_REQ, not modulo 2^width.

## Timing
- Reset values:
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout_pulse`=0.
  - `ptr`=0, state=IDLE, `hold_cnt`=0.
- Reset asserted mid-grant: all outputs return to reset values at the next edge. No `timeout_pulse` is emitted.
- Grant latency: `req` seen in IDLE at edge t produces `gnt` valid after edge t+1.
- Release latency: `done` sampled at edge t produces `gnt`=0 after edge t+1. RELEASE follows, and the next grant is valid after edge t+3 at earliest.
- Maximum grant length is exactly TIMEOUT cycles of `gnt` high. `timeout_pulse` is high during the cycle after the last granted cycle, coincident with `gnt`=0.
- Worst-case wait for a continuously requesting child: (NUM_REQ-1)·(TIMEOUT+2)+1 cycles.
- All outputs are registered; there are no combinational paths from `req` or `done` to outputs.

## Structure
- Shared package `subinst_arb_pkg` holds:
  - `arb_state_t` enum (IDLE, GRANT, RELEASE).
  - `DEFAULT_NUM_REQ`=5 and `DEFAULT_TIMEOUT`=16.
- One sub-module, `rr_priority_pick`: purely combinational.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot pick plus index, using a doubled-vector mask method.
  - The top module instantiates it once and registers its output.

## Test plan
- Reset then `req`=5'b10100 held: `gnt`=5'b00100, `gnt_id`=2 at cycle 1. After `done[2]`, `gnt`=0 for 2 cycles, then `gnt`=5'b10000, `gnt_id`=4.
- All five `req` high, each owner pulses `done` 3 cycles after its grant: grant order is 0,1,2,3,4,0. No owner is granted twice before all others are served.
- Single `req[3]` held, no `done`, TIMEOUT=16: `gnt[3]` high for exactly 16 cycles, then `timeout_pulse`=1 for 1 cycle. Re-grant to 3 follows after the bubble.
- In the same cycle as `hold_cnt`==15, `done[3]`=1 and `done[1]`=1 from a non-owner: release occurs, `timeout_pulse` stays 0, and `done[1]` has no effect.
- Owner 2 drops `req` mid-grant while `req[0]` is high: `gnt` clears the next cycle, then `gnt`=5'b00001 two cycles later, `ptr`=3 before the pick.
- `rst` pulsed for 1 cycle during the grant to owner 4: the next cycle shows `gnt`=0, `gnt_id`=0, `timeout_pulse`=0. With `req`=5'b11111 afterwards, the first grant is to 0.

Source files
------------

// File: rtl/subinst_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : subinst_arb_pkg
//  Description : Shared types and defaults for the sub-instance round-robin
//                arbiter (FSM state encoding, default sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package subinst_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 5;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/subinst_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : subinst_rr_arbiter_if
//  Description : Request/grant bundle between the child instances (master)
//                and the round-robin arbiter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface subinst_rr_arbiter_if
    import subinst_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [c_ID_W-1:0]  gnt_id;
    logic               timeout_pulse;

    // Requesters drive req/done and observe the grant.
    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, timeout_pulse
    );

    // The arbiter observes req/done and drives the grant.
    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, timeout_pulse
    );

endinterface
`default_nettype wire

// File: rtl/subinst_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin picker. Finds the first set req
//                bit at or above ptr, wrapping to bit 0, using a doubled
//                vector whose lower copy is masked below ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import subinst_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] pick_id
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;

    // Lower copy keeps only bits >= ptr; upper copy is the unmasked wrap-around.
    always_comb begin
        w_dbl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dbl[i]           = req[i] && (i >= int'(ptr));
            w_dbl[i + NUM_REQ] = req[i];
        end
    end

    // Lowest set bit of the doubled vector wins; fold the index modulo NUM_REQ.
    always_comb begin
        pick_id = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                pick_id = (i >= NUM_REQ) ? c_ID_W'(i - NUM_REQ) : c_ID_W'(i);
            end
        end
    end

    // One-hot decode of the chosen index, all-zero when nobody requests.
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick[i] = (|req) && (pick_id == c_ID_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/subinst_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : subinst_rr_arbiter
//  Description : Round-robin arbiter for the shared resource of the root
//                module's child instances. Holds a grant until done, request
//                drop or hold timeout, then inserts one bubble cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module subinst_rr_arbiter
    import subinst_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    subinst_rr_arbiter_if.slave  bus
);
    localparam int                c_ID_W     = $clog2(NUM_REQ);
    localparam int                c_HC_W     = $clog2(TIMEOUT);
    localparam logic [c_ID_W-1:0] c_LAST_ID  = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_HC_W-1:0] c_HOLD_MAX = c_HC_W'(TIMEOUT - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [c_ID_W-1:0]  r_gnt_id;
    logic [c_ID_W-1:0]  r_ptr;
    logic [c_HC_W-1:0]  r_hold_cnt;
    logic               r_timeout_pulse;

    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [c_ID_W-1:0]  w_gnt_id_nxt;
    logic [c_ID_W-1:0]  w_ptr_nxt;
    logic [c_HC_W-1:0]  w_hold_nxt;
    logic               w_timeout_nxt;

    logic [NUM_REQ-1:0] w_pick;
    logic [c_ID_W-1:0]  w_pick_id;
    logic               w_owner_done;
    logic               w_owner_req;
    logic               w_hold_expired;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .pick    (w_pick),
        .pick_id (w_pick_id)
    );

    // Only the current owner's done/req bits matter; others are ignored.
    assign w_owner_done   = bus.done[r_gnt_id];
    assign w_owner_req    = bus.req[r_gnt_id];
    assign w_hold_expired = (r_hold_cnt == c_HOLD_MAX);

    // Next-state and next-output logic; release causes are prioritised
    // done > request drop > timeout, so the pulse fires only for a pure timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_gnt_nxt    = w_pick;
                    w_gnt_id_nxt = w_pick_id;
                    w_hold_nxt   = '0;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (w_owner_done || !w_owner_req || w_hold_expired) begin
                    w_timeout_nxt = !w_owner_done && w_owner_req;
                    w_gnt_nxt     = '0;
                    w_ptr_nxt     = (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + 1'b1;
                    w_state_nxt   = RELEASE;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_gnt           <= '0;
            r_gnt_id        <= '0;
            r_ptr           <= '0;
            r_hold_cnt      <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_gnt           <= w_gnt_nxt;
            r_gnt_id        <= w_gnt_id_nxt;
            r_ptr           <= w_ptr_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_timeout_pulse <= w_timeout_nxt;
        end
    end

    assign bus.gnt           = r_gnt;
    assign bus.gnt_valid     = |r_gnt;
    assign bus.gnt_id        = r_gnt_id;
    assign bus.timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_subinst_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subinst_rr_arbiter
//  Description : Directed self-checking bench for subinst_rr_arbiter
//                (NUM_REQ=5, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subinst_rr_arbiter;
    import subinst_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    subinst_rr_arbiter_if #(.NUM_REQ(5)) bus ();

    subinst_rr_arbiter #(
        .NUM_REQ (5),
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_grant(input string tag);
        int w;
        w = 0;
        while (!bus.gnt_valid && w < 12) begin
            tick();
            w++;
        end
        check({tag, "_wait"}, 32'(bus.gnt_valid), 32'd1);
    endtask

    initial begin
        int cnt;
        int e;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;
        tick();
        tick();

        // Reset values
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.gnt_valid), 32'h0);
        check("rst_id",    32'(bus.gnt_id), 32'h0);
        check("rst_tp",    32'(bus.timeout_pulse), 32'h0);

        // Basic grant, done release, bubble, next grant to 4
        rst     = 1'b0;
        bus.req = 5'b10100;
        tick();
        check("t1_gnt",   32'(bus.gnt), 32'h04);
        check("t1_id",    32'(bus.gnt_id), 32'd2);
        check("t1_valid", 32'(bus.gnt_valid), 32'd1);
        bus.done = 5'b00100;
        tick();
        bus.done = '0;
        check("t1_rel0_gnt", 32'(bus.gnt), 32'h0);
        check("t1_rel0_id",  32'(bus.gnt_id), 32'd2);
        tick();
        check("t1_rel1_gnt", 32'(bus.gnt), 32'h0);
        tick();
        check("t1_next_gnt", 32'(bus.gnt), 32'h10);
        check("t1_next_id",  32'(bus.gnt_id), 32'd4);
        bus.req = '0;
        tick();
        tick();
        tick();

        // All requesting, done 3 cycles after grant: order 0,1,2,3,4,0
        bus.req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            e = k % 5;
            wait_grant("rr");
            check("rr_gnt", 32'(bus.gnt), 32'(1 << e));
            check("rr_id",  32'(bus.gnt_id), 32'(e));
            tick();
            tick();
            bus.done = 5'(1 << e);
            tick();
            bus.done = '0;
            check("rr_rel_gnt", 32'(bus.gnt), 32'h0);
            check("rr_rel_tp",  32'(bus.timeout_pulse), 32'h0);
        end
        bus.req = '0;
        tick();
        tick();

        // Timeout: req[3] alone for exactly 16 cycles
        bus.req = 5'b01000;
        wait_grant("to");
        check("to_gnt", 32'(bus.gnt), 32'h08);
        cnt = 0;
        while (bus.gnt[3] && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_len",     32'(cnt), 32'd16);
        check("to_pulse",   32'(bus.timeout_pulse), 32'd1);
        check("to_gnt_off", 32'(bus.gnt), 32'h0);
        tick();
        check("to_pulse_end", 32'(bus.timeout_pulse), 32'd0);
        check("to_bubble",    32'(bus.gnt), 32'h0);
        tick();
        check("to_regrant_gnt", 32'(bus.gnt), 32'h08);
        check("to_regrant_id",  32'(bus.gnt_id), 32'd3);

        // done coincident with timeout plus a non-owner done
        repeat (15) tick();
        check("co_still_gnt", 32'(bus.gnt), 32'h08);
        check("co_no_tp",     32'(bus.timeout_pulse), 32'd0);
        bus.done = 5'b01010;
        tick();
        bus.done = '0;
        check("co_rel_gnt", 32'(bus.gnt), 32'h0);
        check("co_rel_tp",  32'(bus.timeout_pulse), 32'd0);
        check("co_rel_id",  32'(bus.gnt_id), 32'd3);
        bus.req = '0;
        tick();
        tick();

        // Owner 2 abandons while req[0] is pending
        bus.req = 5'b00100;
        wait_grant("ab");
        check("ab_id", 32'(bus.gnt_id), 32'd2);
        bus.req = 5'b00101;
        tick();
        check("ab_hold_gnt", 32'(bus.gnt), 32'h04);
        bus.req = 5'b00001;
        tick();
        check("ab_rel_gnt", 32'(bus.gnt), 32'h0);
        check("ab_ptr",     32'(dut.r_ptr), 32'd3);
        tick();
        check("ab_bub_gnt", 32'(bus.gnt), 32'h0);
        tick();
        check("ab_next_gnt", 32'(bus.gnt), 32'h01);
        check("ab_next_id",  32'(bus.gnt_id), 32'd0);
        bus.req = '0;
        tick();
        tick();
        tick();

        // Reset pulse during grant to owner 4
        bus.req = 5'b10000;
        wait_grant("rs");
        check("rs_gnt", 32'(bus.gnt), 32'h10);
        tick();
        rst     = 1'b1;
        bus.req = 5'b11111;
        tick();
        rst = 1'b0;
        check("rs_gnt0",   32'(bus.gnt), 32'h0);
        check("rs_id0",    32'(bus.gnt_id), 32'd0);
        check("rs_tp0",    32'(bus.timeout_pulse), 32'd0);
        check("rs_valid0", 32'(bus.gnt_valid), 32'd0);
        tick();
        check("rs_first_gnt", 32'(bus.gnt), 32'h01);
        check("rs_first_id",  32'(bus.gnt_id), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
